axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 The block SHALL take parameter RAM_AW, default 16, meaning the word-address width of the attached SRAM (capacity 4*2^RAM_AW bytes).
REQ-002 The block SHALL have port aclk, input, 1, the single clock, with all logic on its rising edge.
REQ-003 The block SHALL have port aresetn, input, 1, the reset: asynchronous and active-low.
REQ-004 The block SHALL have ports arid/araddr/arlen/arsize/arburst, input, 4/32/4/3/2, the read-address payload.
REQ-005 The block SHALL have ports arvalid (input, 1) and arready (output, 1), the read-address handshake.
REQ-006 The block SHALL have ports rid/rdata/rresp/rlast, output, 4/32/2/1, the read-data payload.
REQ-007 The block SHALL have ports rvalid (output, 1) and rready (input, 1), the read-data handshake.
REQ-008 The block SHALL have ports awid/awaddr/awlen/awsize/awburst, input, 4/32/4/3/2, the write-address payload.
REQ-009 The block SHALL have ports awvalid (input, 1) and awready (output, 1), the write-address handshake.
REQ-010 The block SHALL have ports wid/wdata/wstrb/wlast, input, 4/32/4/1, the write-data payload; wid is ignored.
REQ-011 The block SHALL have ports wvalid (input, 1) and wready (output, 1), the write-data handshake.
REQ-012 The block SHALL have ports bid/bresp, output, 4/2, and bvalid (output, 1) / bready (input, 1), the write-response channel.
REQ-013 The block SHALL have ports ar/aw lock, cache and prot, inputs, 2/4/3 each, accepted and ignored.
REQ-014 The block SHALL have ports ram_en/ram_wen/ram_addr/ram_wdata, output, 1/4/RAM_AW/32, the synchronous SRAM request, with ram_wen=0 meaning read.
REQ-015 The block SHALL have port ram_rdata, input, 32, SRAM read data, valid in the cycle after a read with ram_en=1.

Function
REQ-016 FSM states: IDLE, RD_REQ, RD_WAIT, RD_DATA, WR_DATA, WR_RESP. Exactly one AXI transaction is in flight at a time.
REQ-017 In IDLE: grant_rd = arvalid & (~awvalid | prio_rd); grant_wr = awvalid & ~grant_rd. arready=grant_rd and awready=grant_wr, combinationally, in IDLE only.
REQ-018 prio_rd SHALL be 0 after a read grant and 1 after a write grant, giving alternation when both valids are high.
REQ-019 An AR handshake latches id, addr, len, size and burst, clears the beat counter, and moves to RD_REQ.
REQ-020 An AW handshake latches the same fields and moves to WR_DATA.
REQ-021 RD_REQ: ram_en=1, ram_wen=0, ram_addr=addr[RAM_AW+1:2]; next state RD_WAIT.
REQ-022 RD_WAIT: rdata register <= ram_rdata; next state RD_DATA.
REQ-023 RD_DATA: rvalid=1; rid=latched id; rresp=00; rlast=(beat==len). rdata/rid/rlast SHALL be held stable while rready=0.
REQ-024 On R handshake in RD_DATA: if rlast, go to IDLE; else beat+1, advance address, go to RD_REQ. The first rvalid is therefore 3 cycles after the AR handshake cycle.
REQ-025 Address advance: FIXED(00) holds addr. INCR(01) adds 1<<size. WRAP(10) adds 1<<size within an aligned window of (len+1)<<size bytes, wrapping to the window base. burst=11 is treated as INCR.
REQ-026 size>2 on a read: no RAM access occurs, rdata=0, rresp=10 (SLVERR) on every beat; the beat count is still honoured.
REQ-027 WR_DATA: wready=1. On W handshake: ram_en=1, ram_wen=wstrb, ram_addr=addr[RAM_AW+1:2], ram_wdata=wdata, all in the same cycle. On a non-final beat, advance address per REQ-025.
REQ-028 If size>2 on a write, ram_en SHALL be 0 during the W beats.
REQ-029 The write burst ends on the beat where beat==len, regardless of wlast; then the FSM goes to WR_RESP. A wlast mismatch on any beat sets a sticky error flag.
REQ-030 WR_RESP: bvalid=1, bid=latched id, bresp=10 if the error flag or size>2, else 00. On B handshake go to IDLE and clear the flag.
REQ-031 Outside RD_REQ and WR_DATA handshake cycles: ram_en=0, ram_wen=0.
REQ-032 address bits above RAM_AW+1 SHALL be ignored, so addresses alias.

Reset
REQ-033 aresetn=0 SHALL at any time, including mid-burst, force: state IDLE; arready, awready, wready, rvalid, bvalid, ram_en = 0; ram_wen=0; rdata=0; rresp=00; bresp=00; prio_rd=1; beat=0; error flag=0. Interrupted transactions are abandoned without response.

Verification
REQ-034 Write then read: AW addr 0x10, len 0, size 2, wdata 0xDEADBEEF, wstrb F -> bresp 00; then AR 0x10 -> rdata 0xDEADBEEF, rlast=1, rvalid 3 cycles after the AR handshake.
REQ-035 INCR read burst of len 3 from 0x0 with rready toggling 1/0 -> ram_addr sequence 0,1,2,3; data stable while stalled; rlast only on beat 3.
REQ-036 WRAP len 3, size 2, start 0x38 -> word addresses 0xE, 0xF, 0xC, 0xD.
REQ-037 arvalid and awvalid high together three times after reset -> grants read, write, read.
REQ-038 Write of len 1 with wlast=1 on beat 0 -> two RAM writes occur, then bresp=10. Read with arsize=3 -> rresp=10, ram_en stays 0.
REQ-039 aresetn low during RD_DATA of a 4-beat burst -> rvalid=0 immediately, state IDLE; a new AR after release is accepted normally.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI3 slave bridging single-transaction bursts onto a synchronous single-port SRAM.
// Latency: first R beat 3 cycles after AR handshake (then 3 cycles per beat); W beats written in the handshake cycle.
// Backpressure: R/B are held stable until rready/bready; wready only while a write burst is open; one transaction at a time.
module axi_sram_slave #(
  parameter int RAM_AW = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  // read address channel
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [3:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  // read data channel
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  // write address channel
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [3:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  // write data channel
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  // write response channel
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  // synchronous SRAM port
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_RD_DATA = 3'd3,
    S_WR_DATA = 3'd4,
    S_WR_RESP = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  state_e      state_q;
  logic [3:0]  id_q;
  logic [31:0] addr_q;
  logic [3:0]  len_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic [3:0]  beat_q;
  logic [31:0] rdata_q;
  logic        prio_rd_q;
  logic        err_q;

  logic        in_idle;
  logic        grant_rd;
  logic        grant_wr;
  logic        too_wide;
  logic        final_beat;
  logic        r_hs;
  logic        w_hs;
  logic        b_hs;
  logic [31:0] addr_d;
  logic [31:0] step;
  logic [31:0] wrap_mask;

  // Lock/cache/prot, wid and the aliased upper address bits carry no meaning for an SRAM.
  logic unused_ok;
  assign unused_ok = ^{wid, arlock, arcache, arprot, awlock, awcache, awprot, addr_q};

  // Arbitration: reads win unless a write is waiting and it is the write's turn.
  assign in_idle  = (state_q == S_IDLE);
  assign grant_rd = arvalid & (~awvalid | prio_rd_q);
  assign grant_wr = awvalid & ~grant_rd;
  assign arready  = in_idle & grant_rd;
  assign awready  = in_idle & grant_wr;

  // Beats wider than the 32-bit data path are answered with SLVERR and never reach the SRAM.
  assign too_wide   = (size_q > 3'd2);
  assign final_beat = (beat_q == len_q);

  assign rvalid = (state_q == S_RD_DATA);
  assign wready = (state_q == S_WR_DATA);
  assign bvalid = (state_q == S_WR_RESP);
  assign r_hs   = rvalid & rready;
  assign w_hs   = wready & wvalid;
  assign b_hs   = bvalid & bready;

  assign rid   = id_q;
  assign rdata = rdata_q;
  assign rresp = (rvalid & too_wide) ? RESP_SLVERR : RESP_OKAY;
  assign rlast = rvalid & final_beat;

  assign bid   = id_q;
  assign bresp = (bvalid & (err_q | too_wide)) ? RESP_SLVERR : RESP_OKAY;

  // Write beats go straight to the SRAM in the W handshake cycle; reads issue from RD_REQ.
  assign ram_en    = ~too_wide & ((state_q == S_RD_REQ) | w_hs);
  assign ram_wen   = (w_hs & ~too_wide) ? wstrb : 4'b0000;
  assign ram_addr  = addr_q[RAM_AW+1:2];
  assign ram_wdata = wdata;

  // Next beat address; WRAP keeps the base of the (len+1)<<size window and wraps the offset.
  always_comb begin
    step      = 32'd1 << size_q;
    wrap_mask = (({28'd0, len_q} + 32'd1) << size_q) - 32'd1;
    addr_d    = addr_q + step;
    if (burst_q == BURST_FIXED) begin
      addr_d = addr_q;
    end else if (burst_q == BURST_WRAP) begin
      addr_d = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
    end
  end

  // Transaction FSM together with the latched request, beat counter, read data and error flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      id_q      <= 4'd0;
      addr_q    <= 32'd0;
      len_q     <= 4'd0;
      size_q    <= 3'd0;
      burst_q   <= 2'd0;
      beat_q    <= 4'd0;
      rdata_q   <= 32'd0;
      prio_rd_q <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arready) begin
            id_q      <= arid;
            addr_q    <= araddr;
            len_q     <= arlen;
            size_q    <= arsize;
            burst_q   <= arburst;
            beat_q    <= 4'd0;
            prio_rd_q <= 1'b0;
            state_q   <= S_RD_REQ;
          end else if (awready) begin
            id_q      <= awid;
            addr_q    <= awaddr;
            len_q     <= awlen;
            size_q    <= awsize;
            burst_q   <= awburst;
            beat_q    <= 4'd0;
            prio_rd_q <= 1'b1;
            state_q   <= S_WR_DATA;
          end
        end
        S_RD_REQ: begin
          state_q <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          rdata_q <= too_wide ? 32'd0 : ram_rdata;
          state_q <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (r_hs) begin
            if (final_beat) begin
              state_q <= S_IDLE;
            end else begin
              beat_q  <= beat_q + 4'd1;
              addr_q  <= addr_d;
              state_q <= S_RD_REQ;
            end
          end
        end
        S_WR_DATA: begin
          if (w_hs) begin
            if (wlast != final_beat) begin
              err_q <= 1'b1;
            end
            if (final_beat) begin
              state_q <= S_WR_RESP;
            end else begin
              beat_q <= beat_q + 4'd1;
              addr_q <= addr_d;
            end
          end
        end
        S_WR_RESP: begin
          if (b_hs) begin
            err_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: directed transactions against a transaction-level memory model.
// Expected R beats, B responses and SRAM accesses are queued from burst arithmetic and checked every cycle.
// A small SRAM stub sits on the RAM port; all waits are cycle-bounded.
module tb_axi_sram_slave;
  localparam int AW = 8;
  localparam int NW = 1 << AW;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [3:0]  arlen, awlen, arcache, awcache, wstrb, ram_wen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, awvalid, awready, wvalid, wready, wlast;
  logic        rvalid, rready, rlast, bvalid, bready, ram_en;
  logic [AW-1:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  axi_sram_slave #(.RAM_AW(AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // SRAM stub: one-cycle read latency, byte-enabled writes, preloaded on the first clock.
  logic [31:0] sram [NW];
  bit          sram_init;
  always @(posedge aclk) begin
    if (!sram_init) begin
      for (int i = 0; i < NW; i++) sram[i] <= 32'hA500_0000 | 32'(i);
      sram_init <= 1'b1;
    end else if (ram_en) begin
      if (ram_wen == 4'b0000) ram_rdata <= sram[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_wen[b]) sram[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
  end

  // ---------------- model state ----------------
  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
  typedef struct { logic [AW-1:0] addr; logic [3:0] wen; logic [31:0] wdata; } ram_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;

  logic [31:0]   ref_mem [NW];
  rbeat_t        exp_r[$];
  ram_t          exp_ram[$];
  b_t            exp_b[$];
  logic [AW-1:0] ram_log[$];
  logic [31:0]   rdata_log[$];
  logic [1:0]    rresp_log[$];
  logic          rlast_log[$];
  logic [1:0]    bresp_log[$];
  rbeat_t r_head;
  ram_t   m_head;
  b_t     b_head;
  int  total, bad, cyc, ar_cyc;
  bit  lat_pending, prio_m;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [3:0] len,
                                            input logic [2:0] size, input logic [1:0] burst, input int i);
    logic [31:0] sz, win, base;
    sz   = 32'd1 << size;
    win  = (32'(len) + 32'd1) * sz;
    base = a - (a % win);
    case (burst)
      2'b00:   return a;
      2'b10:   return base + (((a - base) + 32'(i) * sz) % win);
      default: return a + 32'(i) * sz;
    endcase
  endfunction

  function automatic logic [AW-1:0] word_of(input logic [31:0] a);
    return AW'((a / 32'd4) % 32'(NW));
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge aclk) begin
    if (!aresetn) begin
      lat_pending = 1'b0;
    end else begin
      if (arvalid && arready) begin
        ar_cyc = cyc;
        lat_pending = 1'b1;
      end
      if (ram_en) begin
        if (exp_ram.size() == 0) chk("ram_en_unexpected", 32'(ram_en), 32'd0);
        else begin
          m_head = exp_ram.pop_front();
          chk("ram_addr", 32'(ram_addr), 32'(m_head.addr));
          chk("ram_wen", 32'(ram_wen), 32'(m_head.wen));
          if (m_head.wen != 4'b0000) chk("ram_wdata", ram_wdata, m_head.wdata);
          ram_log.push_back(ram_addr);
        end
      end
      if (rvalid) begin
        if (lat_pending) begin
          chk("rvalid_latency", 32'(cyc - ar_cyc), 32'd3);
          lat_pending = 1'b0;
        end
        if (exp_r.size() == 0) chk("rvalid_unexpected", 32'(rvalid), 32'd0);
        else begin
          r_head = exp_r[0];
          chk("rid", 32'(rid), 32'(r_head.id));
          chk("rdata", rdata, r_head.data);
          chk("rresp", 32'(rresp), 32'(r_head.resp));
          chk("rlast", 32'(rlast), 32'(r_head.last));
          if (rready) begin
            void'(exp_r.pop_front());
            rdata_log.push_back(rdata);
            rresp_log.push_back(rresp);
            rlast_log.push_back(rlast);
          end
        end
      end
      if (bvalid) begin
        if (exp_b.size() == 0) chk("bvalid_unexpected", 32'(bvalid), 32'd0);
        else begin
          b_head = exp_b[0];
          chk("bid", 32'(bid), 32'(b_head.id));
          chk("bresp", 32'(bresp), 32'(b_head.resp));
          if (bready) begin
            void'(exp_b.pop_front());
            bresp_log.push_back(bresp);
          end
        end
      end
    end
  end

  // ---------------- model: expectations ----------------
  task automatic push_read(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    rbeat_t rb; ram_t rm; logic [AW-1:0] w;
    for (int i = 0; i <= int'(len); i++) begin
      w = word_of(beat_addr(a, len, size, burst, i));
      rb.id = id; rb.last = (i == int'(len));
      if (size > 3'd2) begin
        rb.data = 32'd0; rb.resp = 2'b10;
      end else begin
        rb.data = ref_mem[w]; rb.resp = 2'b00;
        rm.addr = w; rm.wen = 4'b0000; rm.wdata = 32'd0;
        exp_ram.push_back(rm);
      end
      exp_r.push_back(rb);
    end
  endtask

  task automatic push_write(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [31:0] seed,
                            input logic [3:0] strb, input bit wl_all);
    ram_t rm; b_t bb; logic [AW-1:0] w; logic [31:0] d; bit err; bit lastv;
    err = (size > 3'd2);
    for (int i = 0; i <= int'(len); i++) begin
      lastv = wl_all ? 1'b1 : (i == int'(len));
      if (lastv != (i == int'(len))) err = 1'b1;
      if (size <= 3'd2) begin
        w = word_of(beat_addr(a, len, size, burst, i));
        d = seed + 32'(i) * 32'h0101_0101;
        rm.addr = w; rm.wen = strb; rm.wdata = d;
        exp_ram.push_back(rm);
        for (int b = 0; b < 4; b++) if (strb[b]) ref_mem[w][b*8 +: 8] = d[b*8 +: 8];
      end
    end
    bb.id = id; bb.resp = err ? 2'b10 : 2'b00;
    exp_b.push_back(bb);
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic ar_hs(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin @(negedge aclk); if (arready) break; end
    chk("ar_handshake", 32'(arready), 32'd1);
    tick(); arvalid = 1'b0; prio_m = 1'b0;
  endtask

  task automatic aw_hs(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin @(negedge aclk); if (awready) break; end
    chk("aw_handshake", 32'(awready), 32'd1);
    tick(); awvalid = 1'b0; prio_m = 1'b1;
  endtask

  task automatic w_phase(input logic [3:0] len, input logic [31:0] seed, input logic [3:0] strb, input bit wl_all);
    for (int i = 0; i <= int'(len); i++) begin
      wid = 4'hF; wdata = seed + 32'(i) * 32'h0101_0101; wstrb = strb;
      wlast = wl_all ? 1'b1 : (i == int'(len)); wvalid = 1'b1;
      for (int n = 0; n < 50; n++) begin @(negedge aclk); if (wready) break; end
      chk("w_handshake", 32'(wready), 32'd1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic r_drain(input bit toggle);
    for (int n = 0; n < 300 && exp_r.size() > 0; n++) begin
      rready = toggle ? (n % 2 == 0) : 1'b1;
      tick();
    end
    rready = 1'b0;
    chk("r_beats_left", 32'(exp_r.size()), 32'd0);
  endtask

  task automatic b_drain();
    for (int n = 0; n < 50 && exp_b.size() > 0; n++) begin bready = 1'b1; tick(); end
    bready = 1'b0;
    chk("b_left", 32'(exp_b.size()), 32'd0);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    push_read(id, a, len, size, burst);
    ar_hs(id, a, len, size, burst);
    r_drain(toggle);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [31:0] seed,
                          input logic [3:0] strb, input bit wl_all);
    push_write(id, a, len, size, burst, seed, strb, wl_all);
    aw_hs(id, a, len, size, burst);
    w_phase(len, seed, strb, wl_all);
    b_drain();
  endtask

  // Both address channels valid together; exp_rd_lit pins the model's alternation.
  task automatic arb_both(input bit exp_rd_lit, input logic [31:0] seed);
    bit rd;
    chk("arb_model_turn", 32'(prio_m), 32'(exp_rd_lit));
    rd = prio_m;
    if (rd) push_read(4'd1, 32'h10, 4'd0, 3'd2, 2'b01);
    else    push_write(4'd2, 32'h20, 4'd0, 3'd2, 2'b01, seed, 4'hF, 1'b0);
    arid = 4'd1; araddr = 32'h10; arlen = 4'd0; arsize = 3'd2; arburst = 2'b01;
    awid = 4'd2; awaddr = 32'h20; awlen = 4'd0; awsize = 3'd2; awburst = 2'b01;
    arvalid = 1'b1; awvalid = 1'b1;
    @(negedge aclk);
    chk("arb_arready", 32'(arready), 32'(rd));
    chk("arb_awready", 32'(awready), 32'(!rd));
    tick(); arvalid = 1'b0; awvalid = 1'b0;
    prio_m = !rd;
    if (rd) r_drain(1'b0);
    else begin w_phase(4'd0, seed, 4'hF, 1'b0); b_drain(); end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    aresetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = '0; arcache = '0; arprot = '0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = '0; awcache = '0; awprot = '0;
    arvalid = 1'b0; awvalid = 1'b0; wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    rready = 1'b0; bready = 1'b0;
    total = 0; bad = 0; prio_m = 1'b1; lat_pending = 1'b0;
    for (int i = 0; i < NW; i++) ref_mem[i] = 32'hA500_0000 + 32'(i);

    // reset state
    repeat (3) @(posedge aclk); #1;
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_wen", 32'(ram_wen), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    aresetn = 1'b1;
    tick();

    // simultaneous AR/AW: read, write, read
    arb_both(1'b1, 32'h7700_0001);
    arb_both(1'b0, 32'h7700_0002);
    arb_both(1'b1, 32'h7700_0003);

    // single write then read back
    bresp_log.delete(); rdata_log.delete(); rlast_log.delete();
    do_write(4'd3, 32'h10, 4'd0, 3'd2, 2'b01, 32'hDEAD_BEEF, 4'hF, 1'b0);
    chk("wr_single_bresp", 32'(bresp_log[0]), 32'd0);
    do_read(4'd3, 32'h10, 4'd0, 3'd2, 2'b01, 1'b0);
    chk("rd_single_data", rdata_log[0], 32'hDEAD_BEEF);
    chk("rd_single_last", 32'(rlast_log[0]), 32'd1);

    // INCR burst write at 0, then INCR read with rready toggling
    do_write(4'd4, 32'h0, 4'd3, 3'd2, 2'b01, 32'h1111_0000, 4'hF, 1'b0);
    ram_log.delete(); rlast_log.delete(); rdata_log.delete();
    do_read(4'd4, 32'h0, 4'd3, 3'd2, 2'b01, 1'b1);
    chk("incr_count", 32'(ram_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("incr_addr", 32'(ram_log[i]), 32'(i));
    chk("incr_last0", 32'(rlast_log[0]), 32'd0);
    chk("incr_last2", 32'(rlast_log[2]), 32'd0);
    chk("incr_last3", 32'(rlast_log[3]), 32'd1);
    chk("incr_data2", rdata_log[2], 32'h1313_0202);

    // WRAP read from 0x38
    ram_log.delete();
    do_read(4'd5, 32'h38, 4'd3, 3'd2, 2'b10, 1'b0);
    chk("wrap_count", 32'(ram_log.size()), 32'd4);
    chk("wrap_a0", 32'(ram_log[0]), 32'h0E);
    chk("wrap_a1", 32'(ram_log[1]), 32'h0F);
    chk("wrap_a2", 32'(ram_log[2]), 32'h0C);
    chk("wrap_a3", 32'(ram_log[3]), 32'h0D);

    // FIXED burst with a half-word strobe, then read back
    rdata_log.delete();
    do_write(4'd6, 32'h80, 4'd1, 3'd2, 2'b00, 32'h1122_3344, 4'b0011, 1'b0);
    do_read(4'd6, 32'h80, 4'd0, 3'd2, 2'b00, 1'b0);
    chk("fixed_strb_data", rdata_log[0], 32'hA500_3445);

    // early wlast -> both beats still written, SLVERR
    ram_log.delete(); bresp_log.delete();
    do_write(4'd8, 32'h40, 4'd1, 3'd2, 2'b01, 32'h5500_0055, 4'hF, 1'b1);
    chk("wlast_err_writes", 32'(ram_log.size()), 32'd2);
    chk("wlast_err_bresp", 32'(bresp_log[0]), 32'h2);

    // oversize read and write: no RAM traffic, SLVERR
    ram_log.delete(); rresp_log.delete(); rdata_log.delete(); bresp_log.delete();
    do_read(4'd9, 32'h40, 4'd1, 3'd3, 2'b01, 1'b0);
    chk("big_rd_resp0", 32'(rresp_log[0]), 32'h2);
    chk("big_rd_resp1", 32'(rresp_log[1]), 32'h2);
    chk("big_rd_data", rdata_log[1], 32'd0);
    do_write(4'd10, 32'h60, 4'd1, 3'd3, 2'b01, 32'h0BAD_0BAD, 4'hF, 1'b0);
    chk("big_wr_bresp", 32'(bresp_log[0]), 32'h2);
    chk("big_no_ram", 32'(ram_log.size()), 32'd0);

    // upper address bits alias onto the same word
    rdata_log.delete();
    do_write(4'd11, 32'h10 + (32'd1 << (AW + 2)), 4'd0, 3'd2, 2'b01, 32'hCAFE_F00D, 4'hF, 1'b0);
    do_read(4'd11, 32'h10, 4'd0, 3'd2, 2'b01, 1'b0);
    chk("alias_data", rdata_log[0], 32'hCAFE_F00D);

    // reset while a 4-beat read is stalled in the data phase
    push_read(4'd12, 32'h0, 4'd3, 3'd2, 2'b01);
    ar_hs(4'd12, 32'h0, 4'd3, 3'd2, 2'b01);
    rready = 1'b0;
    for (int n = 0; n < 20; n++) begin @(negedge aclk); if (rvalid) break; end
    chk("mid_rvalid_up", 32'(rvalid), 32'd1);
    @(posedge aclk); #1;
    aresetn = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_ram_en", 32'(ram_en), 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_wready", 32'(wready), 32'd0);
    exp_r.delete(); exp_ram.delete(); exp_b.delete();
    prio_m = 1'b1;
    repeat (3) tick();
    aresetn = 1'b1;
    tick();
    rdata_log.delete();
    do_read(4'd13, 32'h10, 4'd0, 3'd2, 2'b01, 1'b0);
    chk("post_rst_data", rdata_log[0], 32'hCAFE_F00D);

    repeat (3) tick();
    chk("ram_left", 32'(exp_ram.size()), 32'd0);
    chk("b_left_end", 32'(exp_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
